// File: rtl/ps2_tx.sv
// Device-side PS/2 transmitter: queues scan-code bytes in a small FIFO and
// serializes each one as an 11-bit PS/2 frame with generated clock and data.
module ps2_tx #(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int IDLE_GAP   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       inhibit,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       busy,
   output logic       frame_done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(2 * CLK_DIV);
   localparam int GW = $clog2(IDLE_GAP * 2 * CLK_DIV);

   localparam logic [PW-1:0] PHASE_LAST = PW'(2 * CLK_DIV - 1);
   localparam logic [PW-1:0] PHASE_HALF = PW'(CLK_DIV);
   localparam logic [GW-1:0] GAP_LAST   = GW'(IDLE_GAP * 2 * CLK_DIV - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [7:0]      mem_d [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [10:0]     frame_q, frame_d;
   logic [3:0]      bit_idx_q, bit_idx_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic            ps2_clk_q, ps2_clk_d;
   logic            ps2_data_q, ps2_data_d;
   logic            frame_done_q, frame_done_d;

   logic            push;
   logic            pop;
   logic [7:0]      head;

   assign in_ready   = (count_q != COUNT_FULL);
   assign push       = in_valid && in_ready;
   assign head       = mem_q[rd_ptr_q];
   assign busy       = (state_q != IDLE) || (count_q != '0);
   assign ps2_clk    = ps2_clk_q;
   assign ps2_data   = ps2_data_q;
   assign frame_done = frame_done_q;

   // Line values are computed for the next cycle so the pins come straight from flops.
   always_comb begin
      state_d      = state_q;
      frame_d      = frame_q;
      bit_idx_d    = bit_idx_q;
      phase_d      = phase_q;
      gap_d        = gap_q;
      ps2_clk_d    = 1'b1;
      ps2_data_d   = 1'b1;
      frame_done_d = 1'b0;
      pop          = 1'b0;
      case (state_q)
         IDLE: begin
            if ((count_q != '0) && !inhibit) begin
               state_d    = SEND;
               frame_d    = {1'b1, ~^head, head, 1'b0};
               bit_idx_d  = 4'd0;
               phase_d    = '0;
               ps2_data_d = 1'b0;
            end
         end
         SEND: begin
            if (inhibit) begin
               state_d = IDLE;
            end else if (phase_q == PHASE_LAST) begin
               if (bit_idx_q == 4'd10) begin
                  pop          = 1'b1;
                  frame_done_d = 1'b1;
                  state_d      = GAP;
                  gap_d        = '0;
               end else begin
                  bit_idx_d  = bit_idx_q + 4'd1;
                  frame_d    = {1'b1, frame_q[10:1]};
                  phase_d    = '0;
                  ps2_data_d = frame_q[1];
               end
            end else begin
               phase_d    = phase_q + PW'(1);
               ps2_clk_d  = (phase_d < PHASE_HALF);
               ps2_data_d = frame_q[0];
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A full FIFO refuses pushes even while popping, since in_ready sees only the count.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         mem_q        <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         frame_q      <= '1;
         bit_idx_q    <= 4'd0;
         phase_q      <= '0;
         gap_q        <= '0;
         ps2_clk_q    <= 1'b1;
         ps2_data_q   <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         frame_q      <= frame_d;
         bit_idx_q    <= bit_idx_d;
         phase_q      <= phase_d;
         gap_q        <= gap_d;
         ps2_clk_q    <= ps2_clk_d;
         ps2_data_q   <= ps2_data_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a line monitor decodes frames at ps2_clk falling edges and
// logs start/done cycles; table vectors plus directed corner-case sequences.
module tb_ps2_tx;

   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int IDLE_GAP   = 2;
   localparam int BIT_CYC    = 2 * CLK_DIV;
   localparam int FRAME_CYC  = 22 * CLK_DIV;
   localparam int NEXT_START = IDLE_GAP * 2 * CLK_DIV + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       inhibit;
   logic       ps2_clk;
   logic       ps2_data;
   logic       busy;
   logic       frame_done;

   ps2_tx #(
      .CLK_DIV   (CLK_DIV),
      .FIFO_DEPTH(FIFO_DEPTH),
      .IDLE_GAP  (IDLE_GAP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inhibit   (inhibit),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;
      logic        parity;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          viol  = 0;
   int          bitn  = 0;
   logic [10:0] cur   = '0;
   logic        prev_clk  = 1'b1;
   logic        prev_data = 1'b1;
   logic [10:0] frames[$];
   int          starts[$];
   int          dones[$];

   // Line monitor: samples 1ns after each rising edge, away from the DUT update.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (rst) begin
         bitn      = 0;
         prev_clk  = 1'b1;
         prev_data = 1'b1;
      end else begin
         if ((ps2_data != prev_data) && !ps2_clk) viol++;
         if (prev_data && !ps2_data && prev_clk && ps2_clk) begin
            starts.push_back(cyc);
            bitn = 0;
         end
         if (prev_clk && !ps2_clk) begin
            cur[bitn] = ps2_data;
            bitn++;
            if (bitn == 11) begin
               frames.push_back(cur);
               bitn = 0;
            end
         end
         if (frame_done) dones.push_back(cyc);
         prev_clk  = ps2_clk;
         prev_data = ps2_data;
      end
   end

   task automatic check_output(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   task automatic clear_log();
      frames.delete();
      starts.delete();
      dones.delete();
   endtask

   task automatic apply_stimulus(input logic [7:0] b, output int push_cyc);
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      push_cyc = cyc;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && (n < limit));
      check_output({name, " idle"}, int'(busy), 0);
   endtask

   task automatic wait_start(input string name, input int limit);
      int n = 0;
      while ((starts.size() == 0) && (n < limit)) begin
         @(negedge clk);
         n++;
      end
      check_output({name, " start seen"}, int'(starts.size() > 0), 1);
   endtask

   task automatic wait_cyc(input int target);
      int n = 0;
      while ((cyc < target) && (n < 2000)) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #500000;
      total++;
      bad++;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      vec_t        vecs[5];
      logic [7:0]  fifo_bytes[6];
      logic [10:0] fifo_frames[6];
      int          acc[6];
      int          pc;
      int          rel;
      int          k;
      int          n;
      logic        rdy;
      logic        r4;

      vecs[0] = '{8'h1A, 11'h434, 1'b0};
      vecs[1] = '{8'h00, 11'h600, 1'b1};
      vecs[2] = '{8'hFF, 11'h7FE, 1'b1};
      vecs[3] = '{8'hF0, 11'h7E0, 1'b1};
      vecs[4] = '{8'h01, 11'h402, 1'b0};
      fifo_bytes  = '{8'h1A, 8'h00, 8'hFF, 8'hF0, 8'h01, 8'h1C};
      fifo_frames = '{11'h434, 11'h600, 11'h7FE, 11'h7E0, 11'h402, 11'h438};

      rst      = 1'b1;
      in_valid = 1'b0;
      inhibit  = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_output("reset ps2_clk", int'(ps2_clk), 1);
      check_output("reset ps2_data", int'(ps2_data), 1);
      check_output("reset busy", int'(busy), 0);
      check_output("reset in_ready", int'(in_ready), 1);
      check_output("reset frame_done", int'(frame_done), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         clear_log();
         apply_stimulus(vecs[i].data, pc);
         wait_idle("vec", 400);
         check_output("vec starts", starts.size(), 1);
         check_output("vec frames", frames.size(), 1);
         check_output("vec dones", dones.size(), 1);
         if (starts.size() > 0) check_output("vec start latency", starts[0] - pc, 1);
         if (frames.size() > 0) begin
            check_output("vec frame", int'(frames[0]), int'(vecs[i].frame));
            check_output("vec parity", int'(frames[0][9]), int'(vecs[i].parity));
         end
         if ((dones.size() > 0) && (starts.size() > 0))
            check_output("vec frame length", dones[0] - starts[0], FRAME_CYC);
      end

      // Hold in_valid across six bytes with a four-entry FIFO.
      clear_log();
      k  = 0;
      n  = 0;
      r4 = 1'b1;
      while ((k < 6) && (n < 1500)) begin
         @(negedge clk);
         in_data  = fifo_bytes[k];
         in_valid = 1'b1;
         rdy      = in_ready;
         @(posedge clk);
         #2;
         if (rdy) begin
            acc[k] = cyc;
            k++;
            if (k == 4) r4 = in_ready;
         end
         n++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check_output("fifo all accepted", k, 6);
      check_output("fifo ready after 4th", int'(r4), 0);
      check_output("fifo 4 back-to-back", acc[3] - acc[0], 3);
      wait_idle("fifo", 1500);
      check_output("fifo frames", frames.size(), 6);
      check_output("fifo dones", dones.size(), 6);
      if (dones.size() > 0) check_output("fifo 5th after done", acc[4] - dones[0], 1);
      for (int i = 0; i < 6; i++) begin
         if (i < frames.size()) check_output("fifo frame order", int'(frames[i]), int'(fifo_frames[i]));
      end
      for (int i = 0; i < 5; i++) begin
         if ((i + 1 < starts.size()) && (i < dones.size()))
            check_output("fifo gap", starts[i+1] - dones[i], NEXT_START);
      end

      // Inhibit during data bit 3 of 0xF0, in the low clock phase.
      clear_log();
      apply_stimulus(8'hF0, pc);
      wait_start("inh", 50);
      if (starts.size() > 0) wait_cyc(starts[0] + 4 * BIT_CYC + 5);
      check_output("inh pre clk low", int'(ps2_clk), 0);
      inhibit = 1'b1;
      @(posedge clk);
      #2;
      check_output("inh abort clk", int'(ps2_clk), 1);
      check_output("inh abort data", int'(ps2_data), 1);
      repeat (20) @(negedge clk);
      check_output("inh no done", dones.size(), 0);
      check_output("inh busy held", int'(busy), 1);
      check_output("inh lines clk", int'(ps2_clk), 1);
      check_output("inh lines data", int'(ps2_data), 1);
      clear_log();
      inhibit = 1'b0;
      @(posedge clk);
      #2;
      rel = cyc;
      wait_idle("inh resend", 400);
      check_output("inh resend frames", frames.size(), 1);
      check_output("inh resend dones", dones.size(), 1);
      if (starts.size() > 0) check_output("inh resend start", starts[0], rel);
      if (frames.size() > 0) check_output("inh resend frame", int'(frames[0]), 11'h7E0);

      // Inhibit held while a byte arrives in IDLE.
      clear_log();
      @(negedge clk);
      inhibit = 1'b1;
      apply_stimulus(8'h1C, pc);
      repeat (20) @(negedge clk);
      check_output("idle inh no start", starts.size(), 0);
      check_output("idle inh data", int'(ps2_data), 1);
      check_output("idle inh busy", int'(busy), 1);
      inhibit = 1'b0;
      @(posedge clk);
      #2;
      rel = cyc;
      wait_idle("idle inh", 400);
      if (starts.size() > 0) check_output("idle inh start", starts[0], rel);
      check_output("idle inh frames", frames.size(), 1);
      if (frames.size() > 0) check_output("idle inh frame", int'(frames[0]), 11'h438);

      // Asynchronous reset during bit 5 with a second byte queued.
      clear_log();
      apply_stimulus(8'h1A, pc);
      apply_stimulus(8'hFF, pc);
      wait_start("rst", 50);
      if (starts.size() > 0) wait_cyc(starts[0] + 5 * BIT_CYC + 5);
      check_output("rst pre clk low", int'(ps2_clk), 0);
      #1;
      rst = 1'b1;
      #1;
      check_output("rst async clk", int'(ps2_clk), 1);
      check_output("rst async data", int'(ps2_data), 1);
      check_output("rst async busy", int'(busy), 0);
      check_output("rst async in_ready", int'(in_ready), 1);
      check_output("rst async done", int'(frame_done), 0);
      @(negedge clk);
      rst = 1'b0;
      clear_log();
      repeat (60) @(negedge clk);
      check_output("rst no start", starts.size(), 0);
      check_output("rst no frame", frames.size(), 0);
      check_output("rst idle busy", int'(busy), 0);

      check_output("data stable in low phase", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
